// File: rtl/bitcell_pkg.sv
// bitcell_pkg: shared types for the bitcell storage array
package bitcell_pkg;
  typedef enum logic {CLEAR, IDLE} state_e;
endpackage

// File: rtl/bitcell_word.sv
// bitcell_word: one WIDTH-bit storage word with per-bit write enable
module bitcell_word #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] be,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = (d & be) | (q_q & ~be);
  always_ff @(posedge clk) q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/bitcell_array.sv
// bitcell_array: WIDTH x DEPTH flop array, masked write port, registered read port, clear sweeper
module bitcell_array
  import bitcell_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH-1:0]  wr_mask,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              err
);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  be [DEPTH];
  logic [WIDTH-1:0]  wd;
  logic              idle, clearing, go, wr_in, rd_in;
  always_comb begin
    idle       = state_q == IDLE;
    clearing   = state_q == CLEAR;
    go         = idle && !clr;
    wr_in      = {1'b0, wr_addr} < DEPTH_L;
    rd_in      = {1'b0, rd_addr} < DEPTH_L;
    state_d    = clearing ? (cnt_q == LAST ? IDLE : CLEAR) : (clr ? CLEAR : IDLE);
    cnt_d      = (clearing && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
    rd_valid_d = go && rd_en;
    rd_data_d  = !rd_valid_d ? rd_data_q : (rd_in ? mem[rd_addr] : '0);
    err_d      = (idle && clr) ? 1'b0
               : err_q || (clearing && (wr_en || rd_en))
                 || (go && ((wr_en && !wr_in) || (rd_en && !rd_in)));
    wd         = clearing ? '0 : wr_data;
    // the sweep owns every word while clearing, so a write can never collide with it
    for (int k = 0; k < DEPTH; k++)
      be[k] = (clearing && cnt_q == ADDR_W'(k)) ? '1
            : (go && wr_en && wr_in && wr_addr == ADDR_W'(k)) ? wr_mask : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    bitcell_word #(.WIDTH(WIDTH)) u_word (
      .clk(clk),
      .be (be[i]),
      .d  (wd),
      .q  (mem[i])
    );
  end
  assign busy     = state_q == CLEAR;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
endmodule

// File: doc/bitcell_array.md
# bitcell_array

Parametrised successor to the 4-bit DQ latch array: a synchronous WIDTH × DEPTH storage array with one masked write port and one registered read port. It replaces level-sensitive latch storage with edge-triggered flops. A built-in clear sequencer zeroes every word after reset or on request. It is the storage primitive for the team's register-file and small-buffer blocks.

## Interface
- WIDTH, 4: bits per word
- DEPTH, 8: number of words, ≥2, not necessarily a power of two
- ADDR_W, $clog2(DEPTH): address width, derived, not overridden
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  pulse: start a full-array clear sweep
- busy  out  1  high while the clear sweep runs; requests are ignored
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- wr_mask  in  WIDTH  per-bit write enable; 1 = bit is written
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  WIDTH  registered read data; holds its value until the next accepted read
- rd_valid  out  1  one-cycle pulse, high in the cycle rd_data is updated
- err  out  1  sticky: request dropped (busy or address ≥ DEPTH); cleared only by reset or clr

## Operation
- FSM states are CLEAR and IDLE. Reset enters CLEAR with sweep counter cnt=0.
- **CLEAR:**
  - each edge writes all-zero to word cnt and increments cnt.
  - On the edge that writes cnt=DEPTH-1, the FSM moves to IDLE.
  - wr_en, rd_en and clr are ignored while in CLEAR.
  - A dropped wr_en or rd_en sets err.
- **IDLE:**
  - clr=1 moves to CLEAR with cnt=0 and clears err.
  - clr has priority over a same-cycle write or read. That write or read is dropped, but err is not set.
- **Write** (IDLE, wr_en=1, wr_addr<DEPTH): for each bit i, mem[wr_addr][i] ← wr_mask[i] ? wr_data[i] : old value.
- **Read** (IDLE, rd_en=1, rd_addr<DEPTH): on the next edge, rd_data ← mem[rd_addr] and rd_valid=1.
- **Out-of-range address** (≥DEPTH): the write is discarded, or the read produces rd_valid=1 with rd_data=0. Either case sets err.
- **Read and write to the same address in the same cycle:** the read returns the pre-write contents (read-first).
- Storage flops are not reset directly; the clear sweep initialises them.

## Timing
- **Reset values:** busy=1, rd_data=0, rd_valid=0, err=0, state=CLEAR, cnt=0.
- **Clear sweep:** lasts exactly DEPTH edges after rst_n deasserts, or after the edge that samples clr. busy falls after the DEPTH-th edge, so the first accepted request is sampled on edge DEPTH+1.
- **busy timing:** busy is a registered state decode and does not depend combinationally on clr.
- **Read latency:** 1 cycle. rd_valid and rd_data appear after the edge that samples rd_en.
- **Write timing:** the write is visible to a read sampled on the following edge.
- **Throughput:** one write and one read per cycle, sustained.
- **Reset mid-sweep:** asynchronous return to reset values; the sweep restarts from cnt=0 after release. Partially written words are irrelevant because every word is rewritten.
- **Reset mid-read:** rd_valid drops immediately and the read is lost.
- **cnt:** ADDR_W bits wide. It never counts past DEPTH-1, so there is no wrap-around when DEPTH is not a power of two.

## Structure
- **Package bitcell_pkg:** state enum {CLEAR, IDLE}.
- **Sub-module bitcell_word:** one WIDTH-bit word with per-bit masked write enable. It is instantiated DEPTH times via generate.
- **Top level:** holds the FSM, sweep counter, address decode, read mux/register and err logic.

## Test plan
- **Reset sweep:** release rst_n with DEPTH=8. busy must be 1 for exactly 8 edges. Then reading all addresses must return 4'b0000 with rd_valid pulsing once per read.
- **Masked write:** write 4'b1111 to addr 3, then write 4'b0000 with mask 4'b0101. Reading addr 3 must return 4'b1010 one cycle after rd_en.
- **Same-cycle read and write:** write 4'b1100 and read addr 5, which holds 4'b0011, in the same cycle. rd_data must be 4'b0011; a read on the next cycle must return 4'b1100.
- **Busy drop:** assert wr_en during the sweep. err must go to 1 and memory must stay all zero. A subsequent clr must clear err and re-sweep in 8 cycles.
- **Out of range:** use DEPTH=6. A write to addr 7 must be discarded with err=1; a read from addr 7 must give rd_valid=1 and rd_data=0.
- **Reset mid-sweep:** assert rst_n low at sweep cycle 3. All outputs must take their reset values immediately, and a full 8-cycle sweep must follow release.
